// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the binary-to-BCD conversion sequencer.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned DIGITS      = 4;
  localparam int unsigned MAX_VAL     = 9999;
  localparam int unsigned ADD3_THRESH = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage : bcd_pkg

// File: rtl/bcd_convert_sequencer_if.sv
// Request/response bundle between the two requesters, the converter and the display driver.
interface bcd_convert_sequencer_if #(
  parameter int unsigned BIN_W = 14
);

  logic                            req0;
  logic [BIN_W-1:0]                bin0;
  logic                            req1;
  logic [BIN_W-1:0]                bin1;
  logic                            ack0;
  logic                            ack1;
  logic                            busy;
  logic                            done;
  logic                            done_id;
  logic                            overflow;
  logic [bcd_pkg::BCD_DIGIT_W-1:0] thousands;
  logic [bcd_pkg::BCD_DIGIT_W-1:0] hundreds;
  logic [bcd_pkg::BCD_DIGIT_W-1:0] tens;
  logic [bcd_pkg::BCD_DIGIT_W-1:0] ones;

  // Requester / display side
  modport master (
    output req0, bin0, req1, bin1,
    input  ack0, ack1, busy, done, done_id, overflow,
    input  thousands, hundreds, tens, ones
  );

  // Converter side
  modport slave (
    input  req0, bin0, req1, bin1,
    output ack0, ack1, busy, done, done_id, overflow,
    output thousands, hundreds, tens, ones
  );

endinterface : bcd_convert_sequencer_if

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift the
// whole {BCD, binary} register left by one bit.
module bcd_dabble_step
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W = 14,
  parameter int unsigned N_DIG = 4
) (
  input  logic [N_DIG*BCD_DIGIT_W+BIN_W-1:0] i_sr,
  output logic [N_DIG*BCD_DIGIT_W+BIN_W-1:0] o_sr
);

  logic [N_DIG*BCD_DIGIT_W+BIN_W-1:0] w_adj;

  // Per-nibble add-3 correction on the BCD field only
  always_comb begin
    w_adj = i_sr;
    for (int unsigned d = 0; d < N_DIG; d++) begin
      if (i_sr[BIN_W + d*BCD_DIGIT_W +: BCD_DIGIT_W] >= BCD_DIGIT_W'(ADD3_THRESH)) begin
        w_adj[BIN_W + d*BCD_DIGIT_W +: BCD_DIGIT_W] =
          i_sr[BIN_W + d*BCD_DIGIT_W +: BCD_DIGIT_W] + BCD_DIGIT_W'(3);
      end
    end
  end

  assign o_sr = w_adj << 1;

endmodule : bcd_dabble_step

// File: rtl/bcd_convert_sequencer.sv
// Shared multi-cycle binary-to-BCD converter with round-robin arbitration
// between two requesters; one double-dabble bit per clock.
module bcd_convert_sequencer #(
  parameter int unsigned BIN_W   = 14,
  parameter int unsigned DIGITS  = bcd_pkg::DIGITS,
  parameter int unsigned MAX_VAL = bcd_pkg::MAX_VAL
) (
  input  logic                    clk,
  input  logic                    rst,
  bcd_convert_sequencer_if.slave  bus
);

  import bcd_pkg::BCD_DIGIT_W;
  import bcd_pkg::state_t;
  import bcd_pkg::ST_IDLE;
  import bcd_pkg::ST_SHIFT;
  import bcd_pkg::ST_DONE;

  localparam int unsigned    BCD_W   = DIGITS * BCD_DIGIT_W;
  localparam int unsigned    SR_W    = BCD_W + BIN_W;
  localparam int unsigned    CNT_W   = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);

  state_t             r_state, w_state_nxt;
  logic [SR_W-1:0]    r_sr, w_sr_nxt, w_sr_step;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_id, w_id_nxt;
  logic               r_last_id, w_last_id_nxt;
  logic               r_ovf_pending, w_ovf_pending_nxt;
  logic               r_ack0, w_ack0_nxt;
  logic               r_ack1, w_ack1_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               r_done_id, w_done_id_nxt;
  logic               r_overflow, w_overflow_nxt;
  logic [BCD_W-1:0]   r_bcd, w_bcd_nxt;

  logic               w_req_any;
  logic               w_pick1;
  logic [BIN_W-1:0]   w_bin_sel;

  bcd_dabble_step #(
    .BIN_W (BIN_W),
    .N_DIG (DIGITS)
  ) u_step (
    .i_sr (r_sr),
    .o_sr (w_sr_step)
  );

  // Round-robin winner: a lone request wins; on a tie the port not served last wins
  always_comb begin
    w_req_any = bus.req0 | bus.req1;
    w_pick1   = bus.req1 & (~bus.req0 | ~r_last_id);
    w_bin_sel = w_pick1 ? bus.bin1 : bus.bin0;
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt       = r_state;
    w_sr_nxt          = r_sr;
    w_cnt_nxt         = r_cnt;
    w_id_nxt          = r_id;
    w_last_id_nxt     = r_last_id;
    w_ovf_pending_nxt = r_ovf_pending;
    w_ack0_nxt        = 1'b0;
    w_ack1_nxt        = 1'b0;
    w_busy_nxt        = r_busy;
    w_done_nxt        = 1'b0;
    w_done_id_nxt     = r_done_id;
    w_overflow_nxt    = r_overflow;
    w_bcd_nxt         = r_bcd;

    unique case (r_state)
      ST_IDLE: begin
        if (w_req_any) begin
          w_sr_nxt          = {{BCD_W{1'b0}}, w_bin_sel};
          w_cnt_nxt         = CNT_W'(BIN_W);
          w_id_nxt          = w_pick1;
          w_ovf_pending_nxt = (w_bin_sel > MAX_BIN);
          w_ack0_nxt        = ~w_pick1;
          w_ack1_nxt        = w_pick1;
          w_busy_nxt        = 1'b1;
          w_state_nxt       = ST_SHIFT;
        end else begin
          w_busy_nxt = 1'b0;
        end
      end

      ST_SHIFT: begin
        w_sr_nxt  = w_sr_step;
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        if (r_ovf_pending) begin
          for (int unsigned d = 0; d < DIGITS; d++) begin
            w_bcd_nxt[d*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_DIGIT_W'(9);
          end
        end else begin
          w_bcd_nxt = r_sr[SR_W-1 -: BCD_W];
        end
        w_overflow_nxt = r_ovf_pending;
        w_done_nxt     = 1'b1;
        w_done_id_nxt  = r_id;
        w_last_id_nxt  = r_id;
        w_state_nxt    = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; async reset leaves port 0 winning the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_sr          <= '0;
      r_cnt         <= '0;
      r_id          <= 1'b0;
      r_last_id     <= 1'b1;
      r_ovf_pending <= 1'b0;
      r_ack0        <= 1'b0;
      r_ack1        <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_done_id     <= 1'b0;
      r_overflow    <= 1'b0;
      r_bcd         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_sr          <= w_sr_nxt;
      r_cnt         <= w_cnt_nxt;
      r_id          <= w_id_nxt;
      r_last_id     <= w_last_id_nxt;
      r_ovf_pending <= w_ovf_pending_nxt;
      r_ack0        <= w_ack0_nxt;
      r_ack1        <= w_ack1_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
      r_done_id     <= w_done_id_nxt;
      r_overflow    <= w_overflow_nxt;
      r_bcd         <= w_bcd_nxt;
    end
  end

  assign bus.ack0      = r_ack0;
  assign bus.ack1      = r_ack1;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.done_id   = r_done_id;
  assign bus.overflow  = r_overflow;
  assign bus.thousands = r_bcd[3*BCD_DIGIT_W +: BCD_DIGIT_W];
  assign bus.hundreds  = r_bcd[2*BCD_DIGIT_W +: BCD_DIGIT_W];
  assign bus.tens      = r_bcd[1*BCD_DIGIT_W +: BCD_DIGIT_W];
  assign bus.ones      = r_bcd[0*BCD_DIGIT_W +: BCD_DIGIT_W];

endmodule : bcd_convert_sequencer

// File: doc/bcd_convert_sequencer.md
Name: bcd_convert_sequencer

Overview:
- Multi-cycle binary-to-BCD converter using the double-dabble (shift, add-3) algorithm, one bit per clock, over a single shared datapath.
- Arbitrates the datapath between two requesters with round-robin priority.
  - Port 0: frequency count.
  - Port 1: gate-time/settings value.
- Sits between the counter/control logic and the seven-segment display driver.
- Replaces the per-user combinational converter to cut area and meet timing.

Parameters:
- BIN_W, 14, binary input width; 14 bits covers 0..16383.
- DIGITS, 4, BCD digits produced (thousands..ones). Fixed at 4 in this revision; other values are unsupported.
- MAX_VAL, 9999, saturation limit; must equal 10^DIGITS - 1.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 conversion request (level, held until ack0).
- bin0  input  BIN_W  requester 0 binary value; must be stable while req0 is high.
- req1  input  1  requester 1 conversion request (level, held until ack1).
- bin1  input  BIN_W  requester 1 binary value.
- ack0  output  1  one-cycle pulse: bin0 sampled, conversion started.
- ack1  output  1  one-cycle pulse: bin1 sampled.
- busy  output  1  high from acceptance until the end of the DONE cycle.
- done  output  1  one-cycle pulse: digit outputs valid and updated.
- done_id  output  1  requester served by the current done (0/1).
- overflow  output  1  registered with the digits; set when the input exceeds MAX_VAL.
- thousands  output  4  BCD digit 3.
- hundreds  output  4  BCD digit 2.
- tens  output  4  BCD digit 1.
- ones  output  4  BCD digit 0.

Behaviour:
- Reset (async, rst=1):
  - State IDLE.
  - All outputs 0: ack0, ack1, busy, done, done_id, overflow, all digits.
  - Shift register and counter cleared; round-robin pointer last_id=1, so req0 wins first.
- FSM: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE, on any clock edge with req0|req1:
  - Winner: if only one request is high, that one; if both are high, the one != last_id.
  - Load the winner's bin into the low BIN_W bits of the shift register (BCD field zeroed).
  - Pulse the winner's ack for 1 cycle; busy=1; cnt=BIN_W; id=winner; go SHIFT.
  - Compare the input against MAX_VAL at load; store the result as ovf_pending.
- SHIFT, each cycle:
  - Every BCD nibble >= 5 gets +3, then the whole register shifts left by 1.
  - cnt decrements; when cnt reaches 1 on the current edge (final shift done), go DONE.
  - Exactly BIN_W SHIFT cycles.
- DONE, for 1 cycle:
  - Digits come from the BCD field; if ovf_pending, digits are forced to 9,9,9,9 and overflow=1, else overflow=0.
  - done=1, done_id=id, last_id=id; go IDLE. busy drops on the next edge.
- Latency:
  - Acceptance edge E.
  - Digits, done and overflow visible after edge E+BIN_W+1 (15 cycles at default).
  - One conversion per BIN_W+2 cycles minimum. Requests are not sampled in SHIFT or DONE.
- Digit outputs hold their value between conversions; done_id holds too.
- Requests deasserted mid-conversion are ignored; the conversion completes.
- A requester re-raising req immediately after its ack while the other waits loses the next arbitration (fairness).
- No combinational path from req to ack; all outputs are registered.
- Reset mid-SHIFT aborts immediately:
  - No done pulse.
  - Digits cleared to 0.
  - Pending requests are re-arbitrated after reset release from IDLE with last_id=1.

Decomposition:
- Shared package bcd_pkg:
  - BCD_DIGIT_W=4, DIGITS=4, MAX_VAL=9999, ADD3_THRESH=5.
  - State encoding constants ST_IDLE, ST_SHIFT, ST_DONE.
- Sub-module bcd_dabble_step (combinational): takes the {BCD field, binary field} register and returns the add-3-corrected, left-shifted register. Instantiated once; it is the only shared datapath.

Test Plan:
- Reset values: hold rst 3 cycles with req0=1 -> all outputs 0, no ack. Release -> ack0 on the first edge.
- Single request: req0=1, bin0=1234 -> ack0 at edge E; done=1, done_id=0, digits 1,2,3,4, overflow=0 after edge E+15; busy high 16 cycles.
- Simultaneous requests after reset: req0=1 (bin0=42), req1=1 (bin1=905).
  - Port 0 served first: digits 0,0,4,2, done_id=0.
  - Port 1 next, ack1 one cycle after done: digits 0,9,0,5, done_id=1.
- Round-robin with req0 held constantly (re-raised after each ack) and req1 held -> acks alternate 0,1,0,1 over 4 conversions.
- Boundaries:
  - bin0=0 -> 0,0,0,0.
  - bin0=9999 -> 9,9,9,9 with overflow=0.
  - bin0=10000 and bin0=16383 -> 9,9,9,9 with overflow=1.
- Reset mid-op: assert rst at SHIFT cycle 7 of bin0=5678 -> done never pulses, digits 0. After release, the held req0 re-converts to 5,6,7,8 in 15 cycles.
